// File: rtl/iseq_fetcher_if.sv
// Instruction fetch bus: read side of the two FWFT instruction FIFOs plus the
// valid/ready pair-output channel toward the dispatcher pipeline.
interface iseq_fetcher_if;
    logic        instr0_fifo_rd_en;
    logic [31:0] instr0_fifo_data;
    logic        instr0_fifo_empty;
    logic        instr1_fifo_rd_en;
    logic [31:0] instr1_fifo_data;
    logic        instr1_fifo_empty;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr0;
    logic [31:0] out_instr1;
    logic        out_instr1_vld;

    modport master (
        output instr0_fifo_rd_en,
        input  instr0_fifo_data,
        input  instr0_fifo_empty,
        output instr1_fifo_rd_en,
        input  instr1_fifo_data,
        input  instr1_fifo_empty,
        output out_valid,
        input  out_ready,
        output out_instr0,
        output out_instr1,
        output out_instr1_vld
    );

    modport slave (
        input  instr0_fifo_rd_en,
        output instr0_fifo_data,
        output instr0_fifo_empty,
        input  instr1_fifo_rd_en,
        output instr1_fifo_data,
        output instr1_fifo_empty,
        input  out_valid,
        output out_ready,
        input  out_instr0,
        input  out_instr1,
        input  out_instr1_vld
    );
endinterface

// File: rtl/iseq_fetcher.sv
// Drains the even/odd instruction FIFOs in lockstep after process_iseq and
// presents instruction pairs to the dispatcher through a registered output.
`ifndef END_ISEQ
`define END_ISEQ 4'hF
`endif

module iseq_fetcher #(
    parameter int unsigned START_DELAY = 2,
    parameter logic [3:0]  END_OPC     = `END_ISEQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        process_iseq,
    output logic        dispatcher_ready,
    iseq_fetcher_if.master bus,
    output logic        iseq_done,
    output logic [15:0] instr_count,
    output logic        seq_err
);

    typedef enum logic [1:0] {IDLE, ARM, FETCH, DRAIN} state_t;

    state_t      state, state_next;
    logic [3:0]  delay_cnt;
    logic        out_valid_q, out_vld1_q;
    logic [31:0] out_i0_q, out_i1_q;

    logic        load, pop0, pop1, load_pair, load_single, err_set, done;
    logic [1:0]  cnt_inc;
    logic        e0, e1;
    logic [3:0]  op0, op1;
    logic [16:0] cnt_sum;

    assign e0  = bus.instr0_fifo_empty;
    assign e1  = bus.instr1_fifo_empty;
    assign op0 = bus.instr0_fifo_data[31:28];
    assign op1 = bus.instr1_fifo_data[31:28];
    assign load = ~out_valid_q | bus.out_ready;

    assign bus.instr0_fifo_rd_en = pop0;
    assign bus.instr1_fifo_rd_en = pop1;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_instr0        = out_i0_q;
    assign bus.out_instr1        = out_i1_q;
    assign bus.out_instr1_vld    = out_vld1_q;
    assign dispatcher_ready      = (state == IDLE) & ~out_valid_q;

    assign cnt_sum = {1'b0, instr_count} + 17'(cnt_inc);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, FIFO pops and datapath control; FETCH rules in priority order
    always_comb begin
        state_next  = state;
        pop0        = 1'b0;
        pop1        = 1'b0;
        load_pair   = 1'b0;
        load_single = 1'b0;
        cnt_inc     = 2'd0;
        err_set     = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (process_iseq) state_next = ARM;
            end
            ARM: begin
                if (delay_cnt <= 4'd1) state_next = FETCH;
            end
            FETCH: begin
                if (load) begin
                    if (e0 && e1) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else if (e0) begin
                        err_set    = 1'b1;
                        state_next = DRAIN;
                    end else if (op0 == END_OPC) begin
                        pop0 = 1'b1;
                        if (e1) begin
                            state_next = IDLE;
                            done       = 1'b1;
                        end else begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (e1) begin
                        pop0        = 1'b1;
                        load_single = 1'b1;
                        cnt_inc     = 2'd1;
                    end else if (op1 == END_OPC) begin
                        pop0        = 1'b1;
                        pop1        = 1'b1;
                        load_single = 1'b1;
                        cnt_inc     = 2'd1;
                        state_next  = IDLE;
                        done        = 1'b1;
                    end else begin
                        pop0      = 1'b1;
                        pop1      = 1'b1;
                        load_pair = 1'b1;
                        cnt_inc   = 2'd2;
                    end
                end
            end
            DRAIN: begin
                pop0 = ~e0;
                pop1 = ~e1;
                if (e0 && e1) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (process_iseq && state != IDLE) err_set = 1'b1;
    end

    // Output register, start delay, saturating count, sticky error and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cnt   <= '0;
            out_valid_q <= 1'b0;
            out_vld1_q  <= 1'b0;
            out_i0_q    <= '0;
            out_i1_q    <= '0;
            iseq_done   <= 1'b0;
            instr_count <= '0;
            seq_err     <= 1'b0;
        end else begin
            iseq_done <= done;
            if (state == IDLE && process_iseq) begin
                instr_count <= '0;
                seq_err     <= 1'b0;
                delay_cnt   <= 4'(START_DELAY);
            end else begin
                if (err_set) seq_err <= 1'b1;
                if (cnt_inc != 2'd0) instr_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                if (state == ARM) delay_cnt <= delay_cnt - 4'd1;
            end
            if (load_pair || load_single) begin
                out_valid_q <= 1'b1;
                out_i0_q    <= bus.instr0_fifo_data;
                out_i1_q    <= load_pair ? bus.instr1_fifo_data : '0;
                out_vld1_q  <= load_pair;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iseq_fetcher.sv
// Directed bench for iseq_fetcher: FWFT FIFO models, accepted-beat log, and
// per-cycle checks against hand-derived expectations.
module tb_iseq_fetcher;

    logic        clk;
    logic        rst;
    logic        process_iseq;
    logic        dispatcher_ready;
    logic        iseq_done;
    logic [15:0] instr_count;
    logic        seq_err;

    iseq_fetcher_if bus ();

    iseq_fetcher #(.START_DELAY(2), .END_OPC(4'hF)) dut (
        .clk              (clk),
        .rst              (rst),
        .process_iseq     (process_iseq),
        .dispatcher_ready (dispatcher_ready),
        .bus              (bus),
        .iseq_done        (iseq_done),
        .instr_count      (instr_count),
        .seq_err          (seq_err)
    );

    localparam logic [31:0] END_W = 32'hF000_0000;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO models (first-word-fall-through)
    logic [31:0] mem0 [0:63];
    logic [31:0] mem1 [0:63];
    logic [5:0]  wr0 = '0, wr1 = '0, rd0 = '0, rd1 = '0;

    assign bus.instr0_fifo_empty = (wr0 == rd0);
    assign bus.instr1_fifo_empty = (wr1 == rd1);
    assign bus.instr0_fifo_data  = mem0[rd0];
    assign bus.instr1_fifo_data  = mem1[rd1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO read pointers advance on pops of non-empty FIFOs
    always @(posedge clk) begin
        if (bus.instr0_fifo_rd_en && wr0 != rd0) rd0 <= rd0 + 6'd1;
        if (bus.instr1_fifo_rd_en && wr1 != rd1) rd1 <= rd1 + 6'd1;
    end

    // Accepted-beat and pop log, sampled on the falling edge
    logic [31:0] lb0 [0:63];
    logic [31:0] lb1 [0:63];
    logic        lv  [0:63];
    int beat_n = 0, pops0 = 0, pops1 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready && beat_n < 64) begin
                lb0[beat_n] <= bus.out_instr0;
                lb1[beat_n] <= bus.out_instr1;
                lv[beat_n]  <= bus.out_instr1_vld;
                beat_n      <= beat_n + 1;
            end
            if (bus.instr0_fifo_rd_en && !bus.instr0_fifo_empty) pops0 <= pops0 + 1;
            if (bus.instr1_fifo_rd_en && !bus.instr1_fifo_empty) pops1 <= pops1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [31:0] d);
        mem0[wr0] = d;
        wr0 = wr0 + 6'd1;
    endtask

    task automatic push1(input logic [31:0] d);
        mem1[wr1] = d;
        wr1 = wr1 + 6'd1;
    endtask

    // Leaves the caller 1ns into cycle T, where T is the edge that sampled the pulse
    task automatic pulse;
        @(posedge clk); #1 process_iseq = 1'b1;
        @(posedge clk); #1 process_iseq = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (iseq_done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_beat(input string tag, input int idx,
                              input logic [31:0] e0, input logic [31:0] e1, input logic ev);
        check({tag, "_i0"}, lb0[idx], e0);
        check({tag, "_i1"}, lb1[idx], e1);
        check({tag, "_vld1"}, 32'(lv[idx]), 32'(ev));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ov"},    32'(bus.out_valid), 0);
        check({tag, "_i0"},    bus.out_instr0, 0);
        check({tag, "_i1"},    bus.out_instr1, 0);
        check({tag, "_vld1"},  32'(bus.out_instr1_vld), 0);
        check({tag, "_done"},  32'(iseq_done), 0);
        check({tag, "_err"},   32'(seq_err), 0);
        check({tag, "_cnt"},   32'(instr_count), 0);
        check({tag, "_rd"},    32'({bus.instr0_fifo_rd_en, bus.instr1_fifo_rd_en}), 0);
        check({tag, "_rdy"},   32'(dispatcher_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bb, p0b, p1b;
        bit seen;
        rst = 1'b1;
        process_iseq = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst");

        // A: six instructions plus END, cycle-accurate latency and throughput
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push0(32'h1A00_0000 + 32'(2 * k));
            push1(32'h1A00_0000 + 32'(2 * k + 1));
        end
        push0(END_W);
        bb = beat_n;
        pulse;
        @(negedge clk); check("A_rdy_fall", 32'(dispatcher_ready), 0);
        @(negedge clk); check("A_arm_nopop", 32'({bus.instr0_fifo_rd_en, bus.instr1_fifo_rd_en}), 0);
        @(negedge clk); check("A_first_pop", 32'({bus.instr0_fifo_rd_en, bus.instr1_fifo_rd_en}), 3);
        check("A_ov_pre", 32'(bus.out_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("A_ov", 32'(bus.out_valid), 1);
            check("A_i0", bus.out_instr0, 32'h1A00_0000 + 32'(2 * k));
            check("A_i1", bus.out_instr1, 32'h1A00_0000 + 32'(2 * k + 1));
            check("A_vld1", 32'(bus.out_instr1_vld), 1);
        end
        @(negedge clk);
        check("A_done", 32'(iseq_done), 1);
        check("A_ov_end", 32'(bus.out_valid), 0);
        check("A_cnt", 32'(instr_count), 6);
        check("A_err", 32'(seq_err), 0);
        check("A_rdy", 32'(dispatcher_ready), 1);
        repeat (2) @(negedge clk);
        check("A_beats", 32'(beat_n - bb), 3);

        // B: five instructions, END in FIFO 1
        push0(32'h2B00_0000); push0(32'h2B00_0002); push0(32'h2B00_0004);
        push1(32'h2B00_0001); push1(32'h2B00_0003); push1(END_W);
        bb = beat_n;
        pulse;
        wait_done("B");
        repeat (2) @(negedge clk);
        check("B_beats", 32'(beat_n - bb), 3);
        check_beat("B0", bb,     32'h2B00_0000, 32'h2B00_0001, 1'b1);
        check_beat("B1", bb + 1, 32'h2B00_0002, 32'h2B00_0003, 1'b1);
        check_beat("B2", bb + 2, 32'h2B00_0004, 32'h0, 1'b0);
        check("B_cnt", 32'(instr_count), 5);
        check("B_err", 32'(seq_err), 0);

        // C: three instructions, no END, ends on empty
        push0(32'h3C00_0000); push0(32'h3C00_0002);
        push1(32'h3C00_0001);
        bb = beat_n;
        pulse;
        wait_done("C");
        repeat (2) @(negedge clk);
        check("C_beats", 32'(beat_n - bb), 2);
        check_beat("C0", bb,     32'h3C00_0000, 32'h3C00_0001, 1'b1);
        check_beat("C1", bb + 1, 32'h3C00_0002, 32'h0, 1'b0);
        check("C_cnt", 32'(instr_count), 3);

        // D: four-cycle backpressure mid-sequence
        for (int k = 0; k < 4; k++) begin
            push0(32'h4D00_0000 + 32'(2 * k));
            push1(32'h4D00_0000 + 32'(2 * k + 1));
        end
        push0(END_W);
        bb = beat_n;
        pulse;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        check("D_valid_seen", 32'(seen), 1);
        @(posedge clk); #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("D_hold_i0", bus.out_instr0, 32'h4D00_0002);
            check("D_hold_i1", bus.out_instr1, 32'h4D00_0003);
            check("D_hold_rd", 32'({bus.instr0_fifo_rd_en, bus.instr1_fifo_rd_en}), 0);
            check("D_hold_rdy", 32'(dispatcher_ready), 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_done("D");
        repeat (2) @(negedge clk);
        check("D_beats", 32'(beat_n - bb), 4);
        for (int k = 0; k < 4; k++)
            check_beat("D", bb + k, 32'h4D00_0000 + 32'(2 * k), 32'h4D00_0000 + 32'(2 * k + 1), 1'b1);
        check("D_cnt", 32'(instr_count), 8);

        // E: final beat still held while already IDLE; ready rises only after accept
        bus.out_ready = 1'b0;
        push0(32'h5E00_0000);
        push1(END_W);
        bb = beat_n;
        pulse;
        repeat (4) @(negedge clk);
        check("E_done", 32'(iseq_done), 1);
        check("E_ov", 32'(bus.out_valid), 1);
        check("E_i0", bus.out_instr0, 32'h5E00_0000);
        check("E_i1", bus.out_instr1, 32'h0);
        check("E_vld1", 32'(bus.out_instr1_vld), 0);
        check("E_cnt", 32'(instr_count), 1);
        for (int i = 0; i < 3; i++) begin
            check("E_rdy_held", 32'(dispatcher_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk); check("E_rdy_pre_accept", 32'(dispatcher_ready), 0);
        @(negedge clk); check("E_rdy_post_accept", 32'(dispatcher_ready), 1);
        check("E_ov_clear", 32'(bus.out_valid), 0);
        check("E_beats", 32'(beat_n - bb), 1);

        // F: FIFO 0 empty while FIFO 1 holds two words
        push1(32'h6F00_0001); push1(32'h6F00_0003);
        bb = beat_n; p0b = pops0; p1b = pops1;
        pulse;
        wait_done("F");
        repeat (2) @(negedge clk);
        check("F_err", 32'(seq_err), 1);
        check("F_pops1", 32'(pops1 - p1b), 2);
        check("F_pops0", 32'(pops0 - p0b), 0);
        check("F_beats", 32'(beat_n - bb), 0);
        check("F_rdy", 32'(dispatcher_ready), 1);

        // G: second process_iseq while stalled in FETCH
        bus.out_ready = 1'b0;
        push0(32'h7000_0000); push0(32'h7000_0002);
        push1(32'h7000_0001); push1(32'h7000_0003);
        bb = beat_n;
        pulse;
        @(negedge clk); check("G_err_cleared", 32'(seq_err), 0);
        repeat (3) @(negedge clk);
        pulse;
        @(negedge clk); check("G_err", 32'(seq_err), 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_done("G");
        repeat (2) @(negedge clk);
        check("G_err_sticky", 32'(seq_err), 1);
        check("G_cnt", 32'(instr_count), 4);
        check("G_beats", 32'(beat_n - bb), 2);
        check_beat("G0", bb,     32'h7000_0000, 32'h7000_0001, 1'b1);
        check_beat("G1", bb + 1, 32'h7000_0002, 32'h7000_0003, 1'b1);

        // H: reset asserted while in FETCH
        push0(32'h8000_0000); push0(32'h8000_0002);
        push1(32'h8000_0001); push1(32'h8000_0003);
        pulse;
        repeat (4) @(negedge clk);
        check("H_ov_pre", 32'(bus.out_valid), 1);
        check("H_i0_pre", bus.out_instr0, 32'h8000_0000);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); check("H_cnt_pre", 32'(instr_count), 4);
        @(negedge clk);
        check_reset_state("H_rst");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iseq_fetcher.md
# iseq_fetcher

Read side of the dual instruction FIFOs filled by the host-side instruction receiver. After the receiver pulses `process_iseq`, the block drains the two FIFOs in lockstep and presents instruction pairs to the dispatcher pipeline:

- instructions 0, 2, 4… come from FIFO 0; instructions 1, 3, 5… come from FIFO 1.
- Fetching stops at the `END_ISEQ` opcode or when both FIFOs are empty.
- `dispatcher_ready` is raised again once the sequence has fully left the block, which gates acceptance of the next instruction sequence.

## Interface
- `START_DELAY`, default 2: cycles to wait after the `process_iseq` pulse before sampling FIFO flags. Covers the receiver's registered last write plus the FIFO flag latency. Range 1–15.
- `END_OPC`, default `` `END_ISEQ ``: 4-bit opcode in `instr[31:28]` that terminates a sequence.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `process_iseq`  in  1  one-cycle pulse: a complete sequence has been written.
- `dispatcher_ready`  out  1  high when state is IDLE and `out_valid` is 0.
- `instr0_fifo_rd_en`  out  1  pop FIFO 0. FIFO 0 is first-word-fall-through; data is valid whenever not empty.
- `instr0_fifo_data`  in  32  FIFO 0 head.
- `instr0_fifo_empty`  in  1  FIFO 0 empty.
- `instr1_fifo_rd_en`, `instr1_fifo_data`, `instr1_fifo_empty`: same as the three FIFO 0 ports, for FIFO 1.
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `out_instr0`  out  32  slot 0 (even) instruction.
- `out_instr1`  out  32  slot 1 (odd) instruction.
- `out_instr1_vld`  out  1  slot 1 holds a real instruction. When 0, `out_instr1` is 0 and must be ignored.
- `iseq_done`  out  1  one-cycle pulse when the sequence ends.
- `instr_count`  out  16  instructions forwarded in the current or last sequence. `END_OPC` is not counted.
- `seq_err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ARM, FETCH, DRAIN.
- IDLE → ARM on `process_iseq`. On that edge: clear `instr_count`, clear `seq_err`, load `delay_cnt = START_DELAY`.
- ARM: decrement `delay_cnt`; go to FETCH when it reaches 0. No pops occur in ARM.
- FETCH: evaluate the rules below in priority order, only when `load = ~out_valid | out_ready`. When `load` is 0, nothing is popped.
  - FIFO 0 empty, FIFO 1 empty: sequence done → IDLE, pulse `iseq_done`.
  - FIFO 0 empty, FIFO 1 not empty: ordering violation → set `seq_err`, go to DRAIN.
  - FIFO 0 head opcode == `END_OPC`: pop FIFO 0 and forward nothing.
    - FIFO 1 empty → done.
    - FIFO 1 not empty → set `seq_err`, go to DRAIN.
  - FIFO 0 not empty, FIFO 1 empty: odd tail.
    - Pop FIFO 0 and load slot 0.
    - Set `out_instr1_vld` = 0; count += 1; stay in FETCH.
  - FIFO 1 head opcode == `END_OPC`:
    - Pop both FIFOs and load slot 0 only; count += 1; done.
  - Otherwise: pop both FIFOs, load the pair, set `out_instr1_vld` = 1; count += 2.
- DRAIN: each cycle, pop every non-empty FIFO and forward nothing. When both FIFOs are empty → IDLE and pulse `iseq_done`.
- `process_iseq` outside IDLE: ignored, and `seq_err` is set.
- `instr_count` saturates at 0xFFFF.
- Output register:
  - loads on `load` in the same cycle as the pops;
  - `out_valid` clears on `out_ready` when no new load occurs;
  - data is held stable while `out_valid & ~out_ready`.
- "Done" in FETCH and DRAIN returns to IDLE immediately. `dispatcher_ready` stays low until the final pair has been accepted.

## Timing
- Reset values:
  - state IDLE;
  - `out_valid`, `out_instr0`, `out_instr1`, `out_instr1_vld`, `iseq_done`, `seq_err` all 0;
  - `instr_count` = 0;
  - both `rd_en` = 0;
  - `dispatcher_ready` = 1 in the first cycle after reset.
- Reset mid-sequence: abandon everything at the next edge. FIFO contents are not flushed by this block.
- `rd_en` outputs are combinational from state, flags and `out_ready`. All other outputs are registered, except `dispatcher_ready`, which is a combinational AND of registers.
- Latency: with `process_iseq` sampled at edge T:
  - pops first occur in cycle T+START_DELAY;
  - `out_valid` is first high in cycle T+START_DELAY+1.
- Throughput: 2 instructions per cycle while `out_ready` is 1 and both FIFOs are non-empty.
- `iseq_done` is high in the cycle after the edge that enters IDLE.
- `dispatcher_ready` falls in the cycle after `process_iseq`.

## Test plan
- 6-instruction sequence plus `END_OPC`:
  - FIFO 0 holds I0, I2, I4, END; FIFO 1 holds I1, I3, I5.
  - `out_ready` = 1.
  - Required: 3 pairs on consecutive cycles, `out_instr1_vld` = 1 on each, then `iseq_done`, `instr_count` = 6, `seq_err` = 0.
- 5 instructions plus END in FIFO 1 (FIFO 0: I0, I2, I4; FIFO 1: I1, I3, END):
  - Required: last beat carries I4 with `out_instr1_vld` = 0; `instr_count` = 5.
- 3 instructions with no END (the maintenance-path style):
  - Required: beats (I0, I1) then (I2, —); done on empty; count = 3.
- Backpressure: hold `out_ready` = 0 for 4 cycles mid-sequence.
  - Required: `out_instr0`/`out_instr1` stable, no `rd_en` asserted, no instruction lost or duplicated.
  - Required: `dispatcher_ready` rises only after the final accept.
- Error cases, each ending back in IDLE:
  - FIFO 0 empty and FIFO 1 holds 2 words → `seq_err` = 1, 2 pops in DRAIN, `iseq_done`.
  - Second `process_iseq` during FETCH → `seq_err` = 1.
- Reset asserted in FETCH → next cycle the block is in IDLE with all outputs at their reset values and `dispatcher_ready` = 1.
